// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 types and constants for the accumulator slice.
package fp_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          FP32_BIAS = 127;
    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP32_PINF = 32'h7F800000;
    localparam logic [31:0] FP32_NINF = 32'hFF800000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } fp_acc_state_e;

endpackage

// File: rtl/fp_acc_if.sv
// fp_acc_if: input element stream and result stream of the FP32 accumulator.
// master = producer/consumer side, slave = accumulator side.
interface fp_acc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp_lzc.sv
// fp_lzc: combinational 28-bit leading-zero counter (28 for an all-zero input).
module fp_lzc (
    input  logic [27:0] din,
    output logic [4:0]  cnt
);
    // scan upward so the highest set bit determines the count
    always_comb begin
        cnt = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (din[i]) cnt = 5'(27 - i);
        end
    end
endmodule

// File: rtl/fp_acc.sv
// fp_acc: iterative FP32 accumulator (align, add, normalize, round), RNE,
// flush-to-zero on subnormal inputs and results, saturation to +/-inf.
// Build option: define FP_ACC_SPECIAL_EN to decode exponent 255 as inf/NaN.
module fp_acc
    import fp_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    fp_acc_if.slave bus
);

    fp_acc_state_e state, nxt;
    fp32_t         acc;
    logic          fresh;      // no element added yet in this vector
    fp32_t         op_p0;
    logic          last_p0;

    logic signed [9:0] exp_c, exp_p1, exp_p2, exp_n, exp_p3;
    logic              sign_c, sign_p1, sign_p2, sign_n, sign_p3;
    logic              sub_c, sub_p1, sub_p2;
    logic [26:0]       big_c, big_p1, small_c, small_p1, sig_n, sig_p3;
    logic [27:0]       sum_p2;
    logic [4:0]        lzc, norm_sh;
    logic              spec_c, spec_p1, spec_p2, spec_p3;
    logic [31:0]       spec_val_c, spec_val_p1, spec_val_p2, spec_val_p3;

    fp32_t       acc_eff, big, sml;
    logic [30:0] a_mag, b_mag;
    logic [26:0] big_sig, sml_sig, shifted, lost;
    logic [7:0]  diff;
    logic [4:0]  shamt;

    function automatic logic [31:0] sat_fp(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] f);
        if (e >= 10'sd255) return s ? FP32_NINF : FP32_PINF;
        if (e <= 10'sd0)   return {s, 31'd0};
        return {s, e[7:0], f};
    endfunction

    function automatic logic [31:0] round_fp(input logic s, input logic signed [9:0] e,
                                             input logic [26:0] sig);
        logic              up;
        logic [24:0]       m;
        logic signed [9:0] er;
        up = sig[2] & (sig[1] | sig[0] | sig[3]);
        m  = {1'b0, sig[26:3]} + {24'd0, up};
        er = e;
        if (m[24]) begin
            m  = m >> 1;
            er = er + 10'sd1;
        end
        return sat_fp(s, er, m[22:0]);
    endfunction

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) nxt = ALIGN;
            ALIGN:   nxt = ADD;
            ADD:     nxt = NORM;
            NORM:    nxt = ROUND;
            ROUND:   nxt = last_p0 ? DONE : IDLE;
            DONE:    if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_data  = acc;
    end

    // accumulator: written in ROUND, cleared on result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            fresh <= 1'b1;
        end else if (state == ROUND) begin
            acc   <= spec_p3 ? spec_val_p3 : round_fp(sign_p3, exp_p3, sig_p3);
            fresh <= 1'b0;
        end else if (state == DONE && bus.out_ready) begin
            acc   <= '0;
            fresh <= 1'b1;
        end
    end

    // ALIGN: order by magnitude, shift smaller significand with guard/round/sticky.
    // An empty accumulator acts as -0 so the first element passes through with its sign.
    always_comb begin
        acc_eff = fresh ? fp32_t'(32'h80000000) : acc;
        a_mag   = (acc_eff.exp == 8'd0) ? 31'd0 : {acc_eff.exp, acc_eff.frac};
        b_mag   = (op_p0.exp == 8'd0) ? 31'd0 : {op_p0.exp, op_p0.frac};
        big     = (b_mag > a_mag) ? op_p0 : acc_eff;
        sml     = (b_mag > a_mag) ? acc_eff : op_p0;
        big_sig = (big.exp == 8'd0) ? 27'd0 : {1'b1, big.frac, 3'd0};
        sml_sig = (sml.exp == 8'd0) ? 27'd0 : {1'b1, sml.frac, 3'd0};
        diff    = big.exp - sml.exp;
        shamt   = (diff > 8'd27) ? 5'd27 : diff[4:0];
        shifted = sml_sig >> shamt;
        lost    = sml_sig & ~(27'h7FFFFFF << shamt);
        sign_c  = big.sign;
        sub_c   = big.sign ^ sml.sign;
        exp_c   = $signed({2'b00, big.exp});
        big_c   = big_sig;
        small_c = {shifted[26:1], shifted[0] | (|lost)};
        spec_c     = 1'b0;
        spec_val_c = '0;
`ifdef FP_ACC_SPECIAL_EN
        if ((acc_eff.exp == 8'hFF && acc_eff.frac != 23'd0) ||
            (op_p0.exp == 8'hFF && op_p0.frac != 23'd0) ||
            (acc_eff.exp == 8'hFF && op_p0.exp == 8'hFF && acc_eff.sign != op_p0.sign)) begin
            spec_c     = 1'b1;
            spec_val_c = FP32_QNAN;
        end else if (acc_eff.exp == 8'hFF) begin
            spec_c     = 1'b1;
            spec_val_c = acc_eff.sign ? FP32_NINF : FP32_PINF;
        end else if (op_p0.exp == 8'hFF) begin
            spec_c     = 1'b1;
            spec_val_c = op_p0.sign ? FP32_NINF : FP32_PINF;
        end
`endif
    end

    fp_lzc u_lzc (
        .din (sum_p2),
        .cnt (lzc)
    );

    // NORM: carry-out shifts right, otherwise shift left until bit 26 is set
    always_comb begin
        norm_sh = lzc - 5'd1;
        sign_n  = sign_p2;
        exp_n   = exp_p2;
        sig_n   = sum_p2[26:0];
        if (sum_p2 == 28'd0) begin
            sign_n = sub_p2 ? 1'b0 : sign_p2;
            exp_n  = '0;
            sig_n  = '0;
        end else if (sum_p2[27]) begin
            sig_n = {sum_p2[27:2], sum_p2[1] | sum_p2[0]};
            exp_n = exp_p2 + 10'sd1;
        end else begin
            sig_n = sum_p2[26:0] << norm_sh;
            exp_n = exp_p2 - $signed({5'd0, norm_sh});
        end
    end

    // datapath stage registers, one stage per FSM step
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            op_p0   <= bus.in_data;
            last_p0 <= bus.in_last;
        end
        // ALIGN -> ADD
        sign_p1     <= sign_c;
        sub_p1      <= sub_c;
        exp_p1      <= exp_c;
        big_p1      <= big_c;
        small_p1    <= small_c;
        spec_p1     <= spec_c;
        spec_val_p1 <= spec_val_c;
        // ADD -> NORM
        sign_p2     <= sign_p1;
        sub_p2      <= sub_p1;
        exp_p2      <= exp_p1;
        sum_p2      <= sub_p1 ? ({1'b0, big_p1} - {1'b0, small_p1})
                              : ({1'b0, big_p1} + {1'b0, small_p1});
        spec_p2     <= spec_p1;
        spec_val_p2 <= spec_val_p1;
        // NORM -> ROUND
        sign_p3     <= sign_n;
        exp_p3      <= exp_n;
        sig_p3      <= sig_n;
        spec_p3     <= spec_p2;
        spec_val_p3 <= spec_val_p2;
    end

endmodule

// File: tb/tb_fp_acc.sv
// tb_fp_acc: directed bench for fp_acc with a real-arithmetic reference model.
module tb_fp_acc;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_acc_if bus ();

    fp_acc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expq[$];
    logic [31:0] m_acc;
    logic        m_empty;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", nm, act, req);
        end
    endtask

    // FP32 bits -> real, subnormals flushed to signed zero
    function automatic real to_r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
`ifdef FP_ACC_SPECIAL_EN
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, (f[22:0] != 23'd0) ? 52'h8000000000000 : 52'd0};
`endif
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // real -> FP32 bits with RNE, flush of tiny results, saturation to inf
    function automatic logic [31:0] to_f(input real r);
        logic [63:0] d;
        logic [24:0] q;
        logic [28:0] rem;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? FP32_QNAN : {d[63], 8'hFF, 23'd0};
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e   = int'(d[62:52]) - 896;
        q   = {2'b01, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h10000000 || (rem == 29'h10000000 && q[0])) q = q + 25'd1;
        if (q[24]) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], 8'(e), q[22:0]};
    endfunction

    // every cycle a result is presented it must equal the oldest expected sum
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                chk("out_data", bus.out_data, expq[0]);
                if (bus.out_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic send(input string nm, input logic [31:0] d, input logic l, output logic [31:0] mv);
        int n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_accept"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        mv = m_empty ? to_f(to_r(d)) : to_f(to_r(m_acc) + to_r(d));
        if (l) begin
            expq.push_back(mv);
            m_empty = 1'b1;
        end else begin
            m_acc   = mv;
            m_empty = 1'b0;
        end
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && !bus.out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, 32'(n), 32'd4);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, 32'(expq.size()), 32'd0);
    endtask

    task automatic run_vec(input string nm, input int n, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] want);
        logic [31:0] els[3];
        logic [31:0] got;
        els = '{e0, e1, e2};
        got = '0;
        for (int i = 0; i < n; i++) send(nm, els[i], (i == n - 1), got);
        chk({nm, "_model"}, got, want);
        drain(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] held;
        m_acc         = '0;
        m_empty       = 1'b1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_vec("sum6", 3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40C00000);
        run_vec("cancel", 2, 32'h40100000, 32'hC0100000, 32'h0, 32'h00000000);
        run_vec("negzero", 2, 32'h80000000, 32'h80000000, 32'h0, 32'h80000000);
        run_vec("mixzero", 2, 32'h00000000, 32'h80000000, 32'h0, 32'h00000000);
        run_vec("tie_even", 2, 32'h3F800000, 32'h33800000, 32'h0, 32'h3F800000);
        run_vec("tie_odd", 2, 32'h3F800001, 32'h33800000, 32'h0, 32'h3F800002);
        run_vec("tie_up", 2, 32'h3F800000, 32'h34400000, 32'h0, 32'h3F800002);
        run_vec("subnorm", 2, 32'h3F800000, 32'h00400000, 32'h0, 32'h3F800000);
        run_vec("lshift", 2, 32'h3F800000, 32'hBF400000, 32'h0, 32'h3E800000);
        run_vec("overflow", 2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h7F800000);
`ifdef FP_ACC_SPECIAL_EN
        run_vec("inf_minus_inf", 2, 32'h7F800000, 32'hFF800000, 32'h0, 32'h7FC00000);
        run_vec("nan_sticky", 3, 32'h7FC00001, 32'h3F800000, 32'h3F800000, 32'h7FC00000);
        run_vec("inf_plus_fin", 2, 32'h3F800000, 32'hFF800000, 32'h0, 32'hFF800000);
`else
        run_vec("big_exp", 2, 32'h7F800000, 32'hFF800000, 32'h0, 32'h00000000);
`endif

        // gap between elements keeps the running sum
        send("gap", 32'h3FC00000, 1'b0, got);
        repeat (6) @(negedge clk);
        send("gap", 32'h3FC00000, 1'b1, got);
        chk("gap_model", got, 32'h40400000);
        drain("gap");

        // backpressure: result held stable while out_ready is low
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send("bp", 32'h40000000, 1'b1, got);
        chk("bp_model", got, 32'h40000000);
        held = bus.out_data;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stable", bus.out_data, held);
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain("bp");
        run_vec("after_bp", 1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000);

        // reset while an element is in ADD
        send("pre_rst", 32'h3F800000, 1'b0, got);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40000000;
        bus.in_last  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_acc", bus.out_data, 32'd0);
        m_acc   = '0;
        m_empty = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_out", {31'd0, bus.out_valid}, 32'd0);
        run_vec("after_rst", 1, 32'h40400000, 32'h0, 32'h0, 32'h40400000);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_acc.md
# fp_acc

Sequential FP32 accumulator that sits directly downstream of `fp_mul`. It consumes a stream of products (`fp_mul.OUT`) over a valid/ready handshake and sums them into a running FP32 total for dot-product and MAC use. It presents the total when the element marked last has been added. Addition is iterative and multi-cycle (align, add, normalize, round), with round-to-nearest-even.

## Interface
Parameters:
- none. Format is fixed at FP32: 1 sign bit, 8 exponent bits, 23 fraction bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` / `in_last` are valid.
- `in_ready`  out  1  block can accept an element. Equals `state==IDLE`, so it reads 1 during and after reset.
- `in_data`  in  32  FP32 addend, normally `fp_mul.OUT`.
- `in_last`  in  1  this element closes the current vector.
- `out_valid`  out  1  `out_data` holds a completed sum. Reset value 0.
- `out_ready`  in  1  downstream accepts `out_data`.
- `out_data`  out  32  accumulated FP32 sum. Reset value 0x00000000.

## Operation
- Accumulator register `acc` resets to +0 (0x00000000). It is cleared to +0 after each result handshake.
- FSM states: IDLE → ALIGN → ADD → NORM → ROUND → (IDLE | DONE) → IDLE.
  - IDLE: `in_ready`=1. On `in_valid&&in_ready`, latch `in_data` and `in_last`, then go to ALIGN.
  - ALIGN: unpack `acc` and the operand with hidden bit. Swap so the larger magnitude is first. Right-shift the smaller significand by the exponent difference (clamped at 27). Keep guard, round and sticky (sticky = OR of all bits shifted out).
  - ADD: add the significands if signs are equal, otherwise subtract. Result is 28 bits wide. Sign is the sign of the larger operand.
  - NORM: on carry-out, shift right by 1 and increment the exponent. Otherwise shift left by the leading-zero count and decrement the exponent. An exact-zero difference yields +0.
  - ROUND: round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalizes. Write the result to `acc`. Go to DONE if the latched last flag is set, else go to IDLE.
  - DONE: `out_valid`=1 and `out_data`=`acc`. Hold both stable until `out_ready`. On handshake, clear `acc` to +0 and go to IDLE.
- Flush-to-zero:
  - A subnormal input is treated as a zero of the same sign.
  - A result whose exponent is ≤0 after rounding is written as a zero of the result's sign.
- Zero rules:
  - (+0)+(-0) = +0.
  - (-0)+(-0) = -0.
  - Exact cancellation gives +0.
- Overflow: a result exponent ≥255 gives ±inf (0x7F800000 / 0xFF800000).

## Timing
- Handshake edge k (IDLE): states ALIGN, ADD, NORM, ROUND occupy the cycles after edges k, k+1, k+2, k+3.
- `acc` updates at edge k+4. `in_ready` is high again after edge k+4, giving one element per 5 cycles at best.
- For a last element, `out_valid` rises after edge k+4. It stays high until the first edge with `out_ready`=1, then drops on that edge.
- `in_valid` while the FSM is not in IDLE: ignored. The upstream block must hold its data.
- `in_valid` low in IDLE: no state change. `acc` is retained across gaps.
- `rst_n` low at any point, including mid-operation or in DONE: immediately return to IDLE, `acc`=+0, `out_valid`=0, `out_data`=0. The element being processed is discarded.

## Configuration
- `FP_ACC_SPECIAL_EN` defined: exponent 255 is decoded as inf/NaN.
  - NaN in either operand gives the canonical qNaN 0x7FC00000.
  - inf + (−inf) gives 0x7FC00000.
  - inf plus a finite value gives that inf.
  - The result is sticky in `acc` until the vector ends.
- `FP_ACC_SPECIAL_EN` undefined: exponent 255 is treated as an ordinary large exponent. Overflow still saturates to ±inf encoding, and there is no NaN handling.

## Structure
- Shared package `fp_pkg`:
  - `fp32_t` packed struct (sign/exp/frac).
  - `FP32_BIAS`=127, `FP32_QNAN`=32'h7FC00000, `FP32_PINF`, `FP32_NINF`.
  - The `fp_acc_state_e` enum.
- Sub-module `fp_lzc`: combinational 28-bit leading-zero counter returning a 5-bit count, instantiated by the NORM stage.

## Test plan
- Elements 0x3F800000, 0x40000000, then 0x40400000 with `in_last`=1 → `out_data`=0x40C00000 (6.0). `in_ready` is low for exactly 4 cycles after each accept.
- Elements 0x40100000, then 0xC0100000 with last → 0x00000000. Elements 0x80000000, then 0x80000000 with last → 0x80000000.
- Tie to even: elements 0x3F800000, then 0x33800000 with last → 0x3F800000. Elements 0x3F800001, then 0x33800000 with last → 0x3F800002.
- Overflow: elements 0x7F7FFFFF, then 0x7F7FFFFF with last → 0x7F800000.
- With `FP_ACC_SPECIAL_EN` defined: elements 0x7F800000, then 0xFF800000 with last → 0x7FC00000.
- Backpressure and reset:
  - Hold `out_ready`=0 for 3 cycles → `out_data` and `out_valid` are stable. The next vector starts from +0.
  - Assert `rst_n`=0 during ADD → `in_ready`=1, `out_valid`=0, `acc`=0.
